// File: rtl/dm_arb_pkg.sv
// ---------------------------------------------------------------------------
// dm_arb_pkg
// Shared definitions for the DMEM port arbiter:
//   - FSM state encodings (IDLE/WAIT/GRANT/ACK) as localparams and an enum
//   - default DMEM address/data widths
//   - statistics counter width and a saturating-increment helper
// ---------------------------------------------------------------------------
package dm_arb_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] GRANT = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_WAIT  = WAIT,
        ST_GRANT = GRANT,
        ST_ACK   = ACK
    } arb_state_e;

    localparam int DM_ADDR_W = 11;
    localparam int DM_DATA_W = 32;
    localparam int STAT_W    = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dm_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// dm_port_arbiter_if
// Debug requester handshake bundle (memory-dump scanner or seg7 source).
//   dbg_req    requester -> arbiter  request, held stable until dbg_ack
//   dbg_we     requester -> arbiter  1 = write, 0 = read
//   dbg_addr   requester -> arbiter  DMEM word address
//   dbg_wdata  requester -> arbiter  write data
//   dbg_ack    arbiter -> requester  one-cycle completion pulse
//   dbg_rdata  arbiter -> requester  read data, valid with dbg_ack, held after
// Modports: master = debug requester, slave = arbiter.
// ---------------------------------------------------------------------------
interface dm_port_arbiter_if
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W = DM_ADDR_W,
    parameter int DATA_W = DM_DATA_W
);
    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;

    modport master (
        output dbg_req,
        output dbg_we,
        output dbg_addr,
        output dbg_wdata,
        input  dbg_ack,
        input  dbg_rdata
    );

    modport slave (
        input  dbg_req,
        input  dbg_we,
        input  dbg_addr,
        input  dbg_wdata,
        output dbg_ack,
        output dbg_rdata
    );
endinterface

// File: rtl/dm_arb_starve_cnt.sv
// ---------------------------------------------------------------------------
// dm_arb_starve_cnt
// Counts cycles a debug request has spent waiting behind the CPU.
//   clk, rst_n  clock, async active-low reset
//   clr         force count to 0 (has priority over inc)
//   inc         add one, saturating at STARVE_LIMIT
//   hit         count has reached STARVE_LIMIT
// ---------------------------------------------------------------------------
module dm_arb_starve_cnt #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic hit
);
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIMIT_V)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit = (cnt_q == LIMIT_V);

endmodule

// File: rtl/dm_port_arbiter.sv
// ---------------------------------------------------------------------------
// dm_port_arbiter
// Shares the single DMEM port (async read, sync write) between the CPU and a
// debug requester. The CPU path is a zero-latency combinational pass-through;
// debug accesses slot into idle CPU cycles, and after STARVE_LIMIT waiting
// cycles the CPU is stalled for exactly one cycle so debug always completes.
//
// Ports
//   clk, rst_n                 CPU clock, async active-low reset
//   cpu_ena/r/w/addr/wdata     CPU request side
//   cpu_rdata                  CPU read data (combinational, 0 during GRANT)
//   cpu_stall                  CPU must hold PC/regfile this cycle
//   dm_ena/r/w/addr/wdata      DMEM controls
//   dm_rdata                   DMEM async read data
//   dbg                        debug handshake (dm_port_arbiter_if.slave)
//   stat_stall, stat_dbg       only when DM_ARB_STATS_EN is defined:
//                              forced-grant count and completed-transfer
//                              count, both 16-bit saturating
//
// Optional feature macro: DM_ARB_STATS_EN
// ---------------------------------------------------------------------------
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W       = DM_ADDR_W,
    parameter int DATA_W       = DM_DATA_W,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              cpu_ena,
    input  logic              cpu_r,
    input  logic              cpu_w,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,

    output logic              dm_ena,
    output logic              dm_r,
    output logic              dm_w,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,

    dm_port_arbiter_if.slave  dbg
`ifdef DM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_stall,
    output logic [STAT_W-1:0] stat_dbg
`endif
);

    arb_state_e        state_q, state_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              cnt_inc;
    logic              cnt_hit;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (dbg.dbg_req) begin
                    state_d = cpu_ena ? ST_WAIT : ST_GRANT;
                end
            end
            ST_WAIT: begin
                // Abort has priority: a withdrawn request never touches DMEM.
                if (!dbg.dbg_req) begin
                    state_d = ST_IDLE;
                end else if (!cpu_ena || cnt_hit) begin
                    state_d = ST_GRANT;
                end
            end
            // GRANT is committed: it finishes even if dbg_req drops.
            ST_GRANT: state_d = ST_ACK;
            // dbg_req is deliberately ignored here; new requests are
            // sampled only from IDLE.
            ST_ACK:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter: counts consecutive WAIT cycles. Entering WAIT
    // from IDLE loads 1 (counter is always 0 outside WAIT), and it is
    // cleared whenever the FSM leaves WAIT.
    // ------------------------------------------------------------------
    assign cnt_inc = (state_d == ST_WAIT);

    dm_arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!cnt_inc),
        .inc   (cnt_inc),
        .hit   (cnt_hit)
    );

    // ------------------------------------------------------------------
    // Port mux. CPU owns the port except in GRANT. The debug side uses the
    // live dbg_* values during GRANT, so the requester must keep address,
    // data and direction stable until dbg_ack.
    // ------------------------------------------------------------------
    always_comb begin
        dm_ena      = cpu_ena;
        dm_r        = cpu_r;
        dm_w        = cpu_w;
        dm_addr     = cpu_addr;
        dm_wdata    = cpu_wdata;
        cpu_rdata   = dm_rdata;
        cpu_stall   = 1'b0;
        dbg_rdata_d = dbg_rdata_q;

        if (state_q == ST_GRANT) begin
            dm_ena    = 1'b1;
            dm_r      = !dbg.dbg_we;
            dm_w      = dbg.dbg_we;
            dm_addr   = dbg.dbg_addr;
            dm_wdata  = dbg.dbg_wdata;
            // Zero rather than debug data so a stalled CPU never sees
            // someone else's read.
            cpu_rdata = '0;
            cpu_stall = 1'b1;
            if (!dbg.dbg_we) begin
                dbg_rdata_d = dm_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_rdata_q <= '0;
        end else begin
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign dbg.dbg_ack   = (state_q == ST_ACK);
    assign dbg.dbg_rdata = dbg_rdata_q;

`ifdef DM_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Statistics. A WAIT->GRANT move with the CPU still requesting can
    // only be the forced (starvation) grant.
    // ------------------------------------------------------------------
    logic [STAT_W-1:0] stat_stall_q, stat_stall_d;
    logic [STAT_W-1:0] stat_dbg_q,   stat_dbg_d;

    always_comb begin
        stat_stall_d = stat_stall_q;
        stat_dbg_d   = stat_dbg_q;
        if ((state_q == ST_WAIT) && (state_d == ST_GRANT) && cpu_ena) begin
            stat_stall_d = sat_inc(stat_stall_q);
        end
        if (state_q == ST_ACK) begin
            stat_dbg_d = sat_inc(stat_dbg_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_stall_q <= '0;
            stat_dbg_q   <= '0;
        end else begin
            stat_stall_q <= stat_stall_d;
            stat_dbg_q   <= stat_dbg_d;
        end
    end

    assign stat_stall = stat_stall_q;
    assign stat_dbg   = stat_dbg_q;
`endif

    // Simultaneous CPU read and write is illegal; it is passed through
    // unchanged but flagged in simulation.
    a_cpu_rw_exclusive : assert property (
        @(posedge clk) disable iff (!rst_n) !(cpu_r && cpu_w)
    );

endmodule
